// File: rtl/seven_seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode 7-segment digits through one shared hex decoder, with blanking gaps.
// New words are applied only at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SHOW_CYCLES  = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] r_active, r_pend;
   logic                    r_pend_full;
   logic                    w_boundary, w_accept, w_digit_blank;
   logic [3:0]              w_nib;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS-1:0]   w_an;

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: hex2seg = 7'h40;
         4'h1: hex2seg = 7'h79;
         4'h2: hex2seg = 7'h24;
         4'h3: hex2seg = 7'h30;
         4'h4: hex2seg = 7'h19;
         4'h5: hex2seg = 7'h12;
         4'h6: hex2seg = 7'h02;
         4'h7: hex2seg = 7'h78;
         4'h8: hex2seg = 7'h00;
         4'h9: hex2seg = 7'h10;
         4'hA: hex2seg = 7'h08;
         4'hB: hex2seg = 7'h03;
         4'hC: hex2seg = 7'h46;
         4'hD: hex2seg = 7'h21;
         4'hE: hex2seg = 7'h06;
         default: hex2seg = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_boundary  = 1'b0;
      w_an        = '1;
      w_seg       = 7'h7F;
      w_nib       = r_active[4*r_idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
      w_digit_blank = (r_idx != '0) && ((r_active >> {r_idx, 2'b00}) == '0);
`else
      w_digit_blank = 1'b0;
`endif
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
            end
         end
         ST_SHOW: begin
            if (!w_digit_blank) begin
               w_an[r_idx] = 1'b0;
               w_seg       = hex2seg(w_nib);
            end
            if (r_cnt == SHOW_LAST) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_boundary  = (r_idx == IDX_LAST);
               w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end
         end
      endcase
   end

   assign load_ready = ~r_pend_full;
   assign w_accept   = load_valid & ~r_pend_full;

   // Accept and transfer are mutually exclusive: accept needs pending empty, transfer needs it full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active    <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else begin
         if (w_boundary && r_pend_full) begin
            r_active    <= r_pend;
            r_pend_full <= 1'b0;
         end
         if (w_accept) begin
            r_pend      <= load_data;
            r_pend_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an         <= '1;
         seg        <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         an         <= w_an;
         seg        <= w_seg;
         frame_done <= w_boundary;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position reference model, vector table, corner sequences, random loads.
// Honours LEADING_ZERO_BLANK_EN in its expectations.
module tb_seven_seg_scan_ctrl;
   localparam int N = 4;
   localparam int S = 4;
   localparam int B = 1;
   localparam int F = N * (B + S);
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int          total, bad;
   int          s;
   logic [15:0] m_active, m_pend;
   logic        m_full;

   typedef struct {
      int         s;
      logic [3:0] an;
      logic [6:0] seg;
      logic       fd;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at s=%0d: got %0h want %0h", nm, s, act, exp);
      end
   endtask

   // Pin values that follow a period t of the frame, given the active word.
   function automatic void calc(input int t, input logic [15:0] act,
                                output logic [3:0] a, output logic [6:0] sg, output logic fd);
      int p, slot, off;
      logic [15:0] hi;
      p    = t % F;
      slot = p / (B + S);
      off  = p % (B + S);
      a    = 4'hF;
      sg   = 7'h7F;
      fd   = (p == F - 1);
      if (off >= B) begin
         hi = act >> (4 * slot);
         if (!(LZ && slot > 0 && hi == 16'h0)) begin
            a  = ~(4'b0001 << slot);
            sg = dec[hi[3:0]];
         end
      end
   endfunction

   task automatic tick();
      logic [3:0] ea;
      logic [6:0] es;
      logic       ef, acc;
      chk("ready", {31'b0, load_ready}, {31'b0, !m_full});
      calc(s, m_active, ea, es, ef);
      acc = load_valid && !m_full;
      if (ef && m_full) begin
         m_active = m_pend;
         m_full   = 1'b0;
      end
      if (acc) begin
         m_pend = load_data;
         m_full = 1'b1;
      end
      s++;
      @(posedge clk);
      #1;
      chk("an", {28'b0, an}, {28'b0, ea});
      chk("seg", {25'b0, seg}, {25'b0, es});
      chk("frame_done", {31'b0, frame_done}, {31'b0, ef});
   endtask

   task automatic run_to(input int t);
      while (s < t) tick();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      load_valid = 1'b0;
      #2;
      chk("rst_an", {28'b0, an}, 32'hF);
      chk("rst_seg", {25'b0, seg}, 32'h7F);
      chk("rst_fd", {31'b0, frame_done}, 32'h0);
      chk("rst_ready", {31'b0, load_ready}, 32'h1);
      @(posedge clk);
      #1;
      chk("rst_an_hold", {28'b0, an}, 32'hF);
      reset    = 1'b0;
      s        = 0;
      m_active = '0;
      m_pend   = '0;
      m_full   = 1'b0;
   endtask

   task automatic load_one(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
      load_data  = 16'($urandom);
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_data = '0;
      total = 0; bad = 0; s = 0;
      m_active = '0; m_pend = '0; m_full = 1'b0;
      tbl[0]  = '{0,  4'hF, 7'h7F, 1'b0};
      tbl[1]  = '{1,  4'hF, 7'h7F, 1'b0};
      tbl[2]  = '{2,  4'hE, 7'h40, 1'b0};
      tbl[3]  = '{5,  4'hE, 7'h40, 1'b0};
      tbl[4]  = '{6,  4'hF, 7'h7F, 1'b0};
      tbl[5]  = '{7,  4'hD, 7'h40, 1'b0};
      tbl[6]  = '{12, 4'hB, 7'h40, 1'b0};
      tbl[7]  = '{16, 4'hF, 7'h7F, 1'b0};
      tbl[8]  = '{17, 4'h7, 7'h40, 1'b0};
      tbl[9]  = '{20, 4'h7, 7'h40, 1'b1};
      tbl[10] = '{21, 4'hF, 7'h7F, 1'b0};
      tbl[11] = '{40, 4'h7, 7'h40, 1'b1};
      @(posedge clk);
      #1;

      // Reset, no load: scan pattern and frame pulse
      do_reset();
      for (int i = 0; i < 12; i++) begin
         run_to(tbl[i].s);
         chk("t1_an", {28'b0, an}, {28'b0, tbl[i].an});
         chk("t1_seg", {25'b0, seg}, {25'b0, tbl[i].seg});
         chk("t1_fd", {31'b0, frame_done}, {31'b0, tbl[i].fd});
      end

      // Mid-frame load takes effect only in the next frame
      do_reset();
      run_to(8);
      load_one(16'h1A3F);
      chk("t2_ready_low", {31'b0, load_ready}, 32'h0);
      run_to(17);
      chk("t2_old_seg", {25'b0, seg}, 32'h40);
      run_to(22); chk("t2_d0", {21'b0, an, seg}, {21'b0, 4'hE, 7'h0E});
      run_to(27); chk("t2_d1", {21'b0, an, seg}, {21'b0, 4'hD, 7'h30});
      run_to(32); chk("t2_d2", {21'b0, an, seg}, {21'b0, 4'hB, 7'h08});
      run_to(37); chk("t2_d3", {21'b0, an, seg}, {21'b0, 4'h7, 7'h79});

      // Back-to-back loads; second offered through the boundary cycle
      do_reset();
      run_to(2);
      load_one(16'h1234);
      load_valid = 1'b1;
      load_data  = 16'h5678;
      run_to(19);
      chk("t4_boundary_ready", {31'b0, load_ready}, 32'h0);
      tick();
      chk("t3_ready_after", {31'b0, load_ready}, 32'h1);
      tick();
      load_valid = 1'b0;
      chk("t3_second_taken", {31'b0, load_ready}, 32'h0);
      run_to(22); chk("t3_first_shown", {25'b0, seg}, 32'h19);
      run_to(42); chk("t3_second_shown", {25'b0, seg}, 32'h00);

      // Reset during SHOW of digit 2 with pending full
      do_reset();
      load_one(16'hABCD);
      run_to(12);
      chk("t5_pre_an", {28'b0, an}, 32'hB);
      do_reset();
      run_to(2);  chk("t5_active_zero", {21'b0, an, seg}, {21'b0, 4'hE, 7'h40});
      run_to(22); chk("t5_pend_dropped", {25'b0, seg}, 32'h40);

      // Leading-zero blanking
      do_reset();
      load_one(16'h0050);
      run_to(22); chk("t6_d0", {21'b0, an, seg}, {21'b0, 4'hE, 7'h40});
      run_to(28); chk("t6_d1", {21'b0, an, seg}, {21'b0, 4'hD, 7'h12});
      run_to(33); chk("t6_d2", {21'b0, an, seg}, LZ ? {21'b0, 4'hF, 7'h7F} : {21'b0, 4'hB, 7'h40});
      run_to(38); chk("t6_d3", {21'b0, an, seg}, LZ ? {21'b0, 4'hF, 7'h7F} : {21'b0, 4'h7, 7'h40});

      // Random loads against the reference model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         tick();
      end
      load_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
